// File: rtl/ctrl_bubble_stage_pkg.sv
// Shared definitions for the ID/EX control bubble stage.
package ctrl_bubble_stage_pkg;

    // Stage state: normal flow, or draining a multi-cycle stall.
    typedef enum logic [0:0] {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    // Bit positions inside the 8-bit control bundle.
    localparam int unsigned ALUOP_HI    = 7;
    localparam int unsigned ALUOP_LO    = 6;
    localparam int unsigned BRANCH_BIT  = 5;
    localparam int unsigned MEMREAD_BIT = 4;
    localparam int unsigned MEMTOREG_BIT = 3;
    localparam int unsigned MEMWRITE_BIT = 2;
    localparam int unsigned ALUSRC_BIT  = 1;
    localparam int unsigned REGWRITE_BIT = 0;

    localparam int unsigned MAX_STALL_DEFAULT = 3;

    // Effective bubble count for a stall request: 0 means 1, long requests clamp.
    function automatic logic [3:0] effLen(input logic [3:0] len, input int unsigned maxStall);
        if (len == 4'd0) begin
            return 4'd1;
        end
        if (32'(len) > maxStall) begin
            return 4'(maxStall);
        end
        return len;
    endfunction

endpackage

// File: rtl/ctrl_bubble_stage_if.sv
// Control/hazard bundle between the ID stage logic and the bubble stage.
interface ctrl_bubble_stage_if #(
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned CNT_W  = 16
);
    logic [CTRL_W-1:0] ctrl_in;
    logic              valid_in;
    logic              hazard;
    logic              stall_req;
    logic [3:0]        stall_len;
    logic              flush;
    logic              hold;
    logic [CTRL_W-1:0] ctrl_out;
    logic              valid_out;
    logic              pc_write;
    logic              ifid_write;
    logic              busy;
    logic [CNT_W-1:0]  bubble_cnt;

    modport master (
        output ctrl_in, valid_in, hazard, stall_req, stall_len, flush, hold,
        input  ctrl_out, valid_out, pc_write, ifid_write, busy, bubble_cnt
    );

    modport slave (
        input  ctrl_in, valid_in, hazard, stall_req, stall_len, flush, hold,
        output ctrl_out, valid_out, pc_write, ifid_write, busy, bubble_cnt
    );
endinterface

// File: rtl/bubble_counter.sv
// Saturating up-counter of inserted bubbles, with synchronous clear.
module bubble_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    // Count up on enable, sticking at the all-ones value.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ctrl_bubble_stage.sv
// ID/EX control register that inserts bubbles for hazards, stalls and flushes.
module ctrl_bubble_stage
    import ctrl_bubble_stage_pkg::*;
#(
    parameter int unsigned CTRL_W    = 8,
    parameter int unsigned MAX_STALL = MAX_STALL_DEFAULT,
    parameter int unsigned CNT_W     = 16
) (
    input logic                clk,
    input logic                reset,
    ctrl_bubble_stage_if.slave bus
);

    state_t            stateQ, stateD;
    logic [3:0]        remQ, remD;
    logic [3:0]        effL;
    logic              bubble;
    logic              advance;
    logic              pcWrite;
    logic [CTRL_W-1:0] ctrlOutQ;
    logic              validOutQ;
    logic [CNT_W-1:0]  bubbleCnt;

    assign effL = effLen(bus.stall_len, MAX_STALL);

    // Next state and bubble decision; priority flush > hold > STALL drain > stall_req > hazard.
    always_comb begin
        stateD  = stateQ;
        remD    = remQ;
        bubble  = 1'b0;
        advance = 1'b1;
        pcWrite = 1'b1;
        if (bus.flush) begin
            // Flush kills the instruction in ID but lets fetch redirect proceed.
            bubble = 1'b1;
            remD   = 4'd0;
            stateD = RUN;
        end else if (bus.hold) begin
            advance = 1'b0;
            pcWrite = 1'b0;
        end else if (stateQ == STALL) begin
            // Requests arriving while draining are dropped, not queued.
            bubble  = 1'b1;
            pcWrite = 1'b0;
            if (remQ <= 4'd1) begin
                remD   = 4'd0;
                stateD = RUN;
            end else begin
                remD = remQ - 4'd1;
            end
        end else if (bus.stall_req) begin
            bubble  = 1'b1;
            pcWrite = 1'b0;
            if (effL > 4'd1) begin
                remD   = effL - 4'd1;
                stateD = STALL;
            end
        end else if (bus.hazard) begin
            bubble  = 1'b1;
            pcWrite = 1'b0;
        end
    end

    // State and pipeline register; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ    <= RUN;
            remQ      <= 4'd0;
            ctrlOutQ  <= '0;
            validOutQ <= 1'b0;
        end else begin
            stateQ <= stateD;
            remQ   <= remD;
            if (advance) begin
                ctrlOutQ  <= bubble ? '0 : bus.ctrl_in;
                validOutQ <= bubble ? 1'b0 : bus.valid_in;
            end
        end
    end

    bubble_counter #(
        .CNT_W(CNT_W)
    ) bubbleCounter (
        .clk(clk),
        .clr(reset),
        .en (bubble),
        .cnt(bubbleCnt)
    );

    assign bus.ctrl_out   = ctrlOutQ;
    assign bus.valid_out  = validOutQ;
    assign bus.pc_write   = pcWrite;
    assign bus.ifid_write = pcWrite;
    assign bus.busy       = (stateQ == STALL);
    assign bus.bubble_cnt = bubbleCnt;

endmodule
